// File: rtl/dma_w_burst_ctrl.sv
// DMA write burst controller: splits a word transfer into 4 KB-safe bursts
// and hands each one to an AXI write engine, with timeout and error reporting.
module dma_w_burst_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DMA_DATA_W = 32,
    parameter int XFER_W     = 16,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [XFER_W-1:0] xfer_words,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [XFER_W-1:0] words_done,
    output logic              eng_valid,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [7:0]        eng_len,
    input  logic              eng_dma_ready,
    input  logic              eng_error
);
    localparam int BPB   = DMA_DATA_W / 8;
    localparam int OFF_W = $clog2(BPB);
    localparam int CW    = (XFER_W > 13) ? XFER_W : 13;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CALC      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACC  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FIN       = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, eng_addr_q, eng_addr_d;
    logic [XFER_W-1:0] rem_q, rem_d, words_done_q, words_done_d;
    logic [8:0]        beats_q, beats_d;
    logic [7:0]        eng_len_q, eng_len_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              error_q, error_d, eng_valid_q, eng_valid_d;
    logic [CW-1:0]     room_s, beats_s;
    logic              tmo_hit_s, misaligned_s;

    function automatic logic [CW-1:0] min2(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Burst sizing: bounded by remaining beats, MAX_BURST and room left in the 4 KB page
    always_comb begin
        room_s       = CW'((13'h1000 - {1'b0, addr_q[11:0]}) >> OFF_W);
        beats_s      = min2(min2(CW'(rem_q), CW'(MAX_BURST)), room_s);
        tmo_hit_s    = (tmo_q == TW'(TIMEOUT - 1));
        misaligned_s = ((start_addr & ADDR_W'(BPB - 1)) != {ADDR_W{1'b0}});
    end

    // Next-state and datapath updates
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        words_done_d = words_done_q;
        beats_d      = beats_q;
        eng_addr_d   = eng_addr_q;
        eng_len_d    = eng_len_q;
        error_d      = error_q;
        tmo_d        = {TW{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d       = start_addr;
                    rem_d        = xfer_words;
                    words_done_d = {XFER_W{1'b0}};
                    error_d      = misaligned_s;
                    if (misaligned_s || (xfer_words == {XFER_W{1'b0}})) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                beats_d    = 9'(beats_s);
                eng_len_d  = 8'(beats_s - CW'(1));
                eng_addr_d = addr_q;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                // Ready already low on the first ISSUE cycle means the engine is still busy
                if (!eng_dma_ready) begin
                    if (tmo_q == {TW{1'b0}}) begin
                        state_d = S_WAIT_ACC;
                    end else begin
                        state_d = S_WAIT_DONE;
                    end
                end else if (tmo_hit_s) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WAIT_ACC: begin
                if (eng_dma_ready) begin
                    state_d = S_ISSUE;
                end else if (tmo_hit_s) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (eng_dma_ready) begin
                    if (eng_error) begin
                        error_d = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        addr_d       = addr_q + (ADDR_W'(beats_q) << OFF_W);
                        rem_d        = rem_q - XFER_W'(beats_q);
                        words_done_d = words_done_q + XFER_W'(beats_q);
                        if (rem_q == XFER_W'(beats_q)) begin
                            state_d = S_FIN;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end else if (tmo_hit_s) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        eng_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            rem_q        <= {XFER_W{1'b0}};
            words_done_q <= {XFER_W{1'b0}};
            beats_q      <= 9'd0;
            eng_addr_q   <= {ADDR_W{1'b0}};
            eng_len_q    <= 8'd0;
            tmo_q        <= {TW{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            eng_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            words_done_q <= words_done_d;
            beats_q      <= beats_d;
            eng_addr_q   <= eng_addr_d;
            eng_len_q    <= eng_len_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            eng_valid_q  <= eng_valid_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_done = words_done_q;
    assign eng_valid  = eng_valid_q;
    assign eng_addr   = eng_addr_q;
    assign eng_len    = eng_len_q;

endmodule

// File: tb/tb_dma_w_burst_ctrl.sv
// Bench for dma_w_burst_ctrl: behavioural write engine plus a burst scoreboard.
module tb_dma_w_burst_ctrl;
    localparam int TMO = 20;

    logic        clk, rst_n, start;
    logic [31:0] start_addr;
    logic [15:0] xfer_words;
    logic        busy, done, error, eng_valid, eng_dma_ready, eng_error;
    logic [15:0] words_done;
    logic [31:0] eng_addr;
    logic [7:0]  eng_len;

    dma_w_burst_ctrl #(
        .ADDR_W(32), .DMA_DATA_W(32), .XFER_W(16), .MAX_BURST(16), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .xfer_words(xfer_words), .busy(busy), .done(done), .error(error),
        .words_done(words_done), .eng_valid(eng_valid), .eng_addr(eng_addr),
        .eng_len(eng_len), .eng_dma_ready(eng_dma_ready), .eng_error(eng_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [39:0] exp_q[$];
    logic [39:0] obs[256];
    int          acc_cnt = 0, done_cnt = 0, valid_cnt = 0;
    int          acc_base = 0, err_at = 0, rd_ptr = 0;
    bit          stuck = 1'b0;
    bit          pend = 1'b0;
    int          lat = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Engine model: accepts valid while ready, drops ready a cycle later, returns after lat
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (eng_valid) valid_cnt++;
        if (!rst_n) begin
            eng_dma_ready = 1'b1;
            eng_error     = 1'b0;
            pend          = 1'b0;
            lat           = 0;
        end else if (!stuck) begin
            if (pend) begin
                pend          = 1'b0;
                eng_dma_ready = 1'b0;
                lat           = int'($urandom_range(2, 5));
            end else if (eng_dma_ready && eng_valid) begin
                pend             = 1'b1;
                eng_error        = 1'b0;
                obs[acc_cnt % 256] = {eng_addr, eng_len};
                acc_cnt++;
            end else if (!eng_dma_ready) begin
                lat--;
                if (lat <= 0) begin
                    eng_dma_ready = 1'b1;
                    eng_error     = ((acc_cnt - acc_base) == err_at);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drain_sb(input string tag);
        logic [39:0] e;
        while (rd_ptr != acc_cnt) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hFF_FFFF_FFFF;
            check_eq({tag, "_burst"}, 64'(obs[rd_ptr % 256]), 64'(e));
            rd_ptr++;
        end
        check_eq({tag, "_bursts_missing"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin
            cyc();
            n++;
        end
        check_eq({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic run_xfer(input logic [31:0] addr, input logic [15:0] words,
                            input int err_burst, input string tag);
        logic [31:0] a;
        int r, b, room, k, wd, d0, v0;
        bit mis, exp_err;
        a = addr; r = int'(words); k = 0; wd = 0;
        mis = (addr[1:0] != 2'd0);
        exp_err = mis;
        if (!mis) begin
            while (r > 0) begin
                room = (4096 - int'(a[11:0])) / 4;
                b = (r < 16) ? r : 16;
                if (b > room) b = room;
                exp_q.push_back({a, 8'(b - 1)});
                k++;
                if (k == err_burst) begin
                    exp_err = 1'b1;
                    break;
                end
                a = a + 32'(b * 4);
                r = r - b;
                wd = wd + b;
            end
        end
        acc_base = acc_cnt;
        err_at = err_burst;
        d0 = done_cnt;
        v0 = valid_cnt;
        start = 1'b1; start_addr = addr; xfer_words = words;
        cyc();
        start = 1'b0;
        check_eq({tag, "_busy"}, 64'(busy), 64'd1);
        if (mis || words == 16'd0) begin
            check_eq({tag, "_done_early"}, 64'(done), 64'd1);
        end else begin
            check_eq({tag, "_valid_c1"}, 64'(eng_valid), 64'd0);
            cyc();
            check_eq({tag, "_valid_c2"}, 64'(eng_valid), 64'd1);
        end
        wait_done(tag, d0);
        check_eq({tag, "_error"}, 64'(error), 64'(exp_err));
        check_eq({tag, "_words_done"}, 64'(words_done), 64'(wd));
        repeat (3) cyc();
        check_eq({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
        check_eq({tag, "_error_hold"}, 64'(error), 64'(exp_err));
        if (mis || words == 16'd0) begin
            check_eq({tag, "_valid_cycles"}, 64'(valid_cnt - v0), 64'd0);
        end
        drain_sb(tag);
    endtask

    initial begin
        int d0, v0, n;
        rst_n = 1'b0; start = 1'b0; start_addr = 32'd0; xfer_words = 16'd0;
        repeat (3) cyc();
        check_eq("reset_state", 64'({busy, done, error, eng_valid, words_done, eng_addr, eng_len}), 64'd0);
        rst_n = 1'b1;
        cyc();

        run_xfer(32'h0000_1000, 16'd40, 0, "three_bursts");
        run_xfer(32'h0000_1FF0, 16'd10, 0, "page_split");
        run_xfer(32'h0000_1000, 16'd40, 2, "eng_err");
        run_xfer(32'h0000_1002, 16'd5, 0, "misaligned");
        run_xfer(32'h0000_0000, 16'd0, 0, "zero_words");
        run_xfer(32'h0000_0FFC, 16'd1, 0, "single_page_end");
        run_xfer(32'hFFFF_FFC0, 16'd32, 0, "addr_wrap");

        // Engine never accepts: ISSUE must time out; a start while busy is ignored
        stuck = 1'b1;
        d0 = done_cnt; v0 = valid_cnt;
        start = 1'b1; start_addr = 32'h0000_3000; xfer_words = 16'd8;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        start = 1'b1; start_addr = 32'h0000_5000; xfer_words = 16'd3;
        cyc();
        start = 1'b0;
        check_eq("tmo_params_held", 64'({eng_addr, eng_len}), 64'({32'h0000_3000, 8'd7}));
        wait_done("tmo", d0);
        check_eq("tmo_error", 64'(error), 64'd1);
        check_eq("tmo_valid_dropped", 64'(eng_valid), 64'd0);
        check_eq("tmo_valid_cycles", 64'(valid_cnt - v0), 64'(TMO));
        repeat (4) cyc();
        check_eq("tmo_done_pulses", 64'(done_cnt - d0), 64'd1);
        check_eq("tmo_no_restart", 64'(busy), 64'd0);
        stuck = 1'b0;
        cyc();

        // Reset while waiting for the engine to finish a burst
        acc_base = acc_cnt; err_at = 0;
        exp_q.push_back({32'h0000_2000, 8'd15});
        d0 = done_cnt;
        start = 1'b1; start_addr = 32'h0000_2000; xfer_words = 16'd20;
        cyc();
        start = 1'b0;
        n = 0;
        while (!(acc_cnt != acc_base && !eng_valid) && n < 200) begin
            cyc();
            n++;
        end
        check_eq("rst_reached_wait", 64'(acc_cnt != acc_base), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_outputs", 64'({busy, done, error, eng_valid, words_done, eng_addr, eng_len}), 64'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        check_eq("rst_no_done", 64'(done_cnt - d0), 64'd0);
        drain_sb("rst");
        run_xfer(32'h0000_2000, 16'd20, 0, "post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dma_w_burst_ctrl.md
DMA_W_BURST_CTRL -- requirements
Module: dma_w_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: byte address width.
REQ-002 Parameter DMA_DATA_W, default 32: data beat width; bytes per beat BPB = DMA_DATA_W/8.
REQ-003 Parameter XFER_W, default 16: width of the total-words field.
REQ-004 Parameter MAX_BURST, default 16: maximum beats per burst, range 1..256.
REQ-005 Parameter TIMEOUT, default 1024: cycles allowed per wait state before abort.
REQ-006 Reset and clock: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  one-cycle transfer request, sampled in IDLE only.
REQ-010 start_addr  in  ADDR_W  first byte address, must be BPB-aligned.
REQ-011 xfer_words  in  XFER_W  total beats to write; 0 means no-op.
REQ-012 busy  out  1  high from the cycle after accepted start until done.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 error  out  1  sticky failure flag, cleared on next accepted start.
REQ-015 words_done  out  XFER_W  beats completed in successful bursts.
REQ-016 eng_valid  out  1  burst request to the AXI write engine.
REQ-017 eng_addr  out  ADDR_W  burst start address (engine awaddr source).
REQ-018 eng_len  out  8  burst beats minus one (engine awlen source).
REQ-019 eng_dma_ready  in  1  engine idle, registered; drops after it accepts a request.
REQ-020 eng_error  in  1  engine response-error flag, valid when eng_dma_ready returns high.

Function
REQ-021 States: IDLE, CALC, ISSUE, WAIT_ACC, WAIT_DONE, FIN; all state registers are updated on the clk rising edge only.
REQ-022 IDLE: on start, latch start_addr and xfer_words, clear error and words_done, set busy, and go to CALC.
REQ-023 IDLE start with start_addr[log2(BPB)-1:0] != 0: set error and go to FIN; no burst is issued.
REQ-024 IDLE start with xfer_words == 0: go to FIN with error clear; no burst is issued.
REQ-025 CALC: compute beats = min(remaining, MAX_BURST, (4096 - addr[11:0])/BPB), which is always >= 1; register eng_len = beats-1 and eng_addr = current address; go to ISSUE.
REQ-026 ISSUE: assert eng_valid and hold it, with eng_addr and eng_len stable, until eng_dma_ready is sampled low; then deassert eng_valid and go to WAIT_DONE.
REQ-027 WAIT_ACC: entered from ISSUE only if eng_dma_ready is low on entry (stale idle); wait for eng_dma_ready high, then return to ISSUE.
REQ-028 WAIT_DONE: on eng_dma_ready high, sample eng_error.
- If eng_error is 1: set error and go to FIN.
- Otherwise: address += beats*BPB, remaining -= beats, words_done += beats.
- Then go to CALC if remaining != 0, else go to FIN.
REQ-029 Address arithmetic is modulo 2^ADDR_W; a burst never crosses a 4 KB boundary.
REQ-030 Timeout: a cycle counter is cleared on entry to ISSUE, WAIT_ACC and WAIT_DONE; if it reaches TIMEOUT in one of these states, set error, drop eng_valid and go to FIN.
REQ-031 FIN: pulse done for one cycle, clear busy, and return to IDLE; error holds its value.
REQ-032 start while busy is ignored; latched parameters are unaffected.
REQ-033 Latency: start to first eng_valid is 2 cycles (IDLE→CALC→ISSUE).
REQ-034 Latency: final eng_dma_ready rise to done is 1 cycle (WAIT_DONE→FIN).
REQ-035 eng_valid is 0 in every state except ISSUE.

Reset
REQ-036 rst_n low asynchronously forces: state IDLE, busy 0, done 0, error 0, words_done 0, eng_valid 0, eng_addr 0, eng_len 0, all counters 0.
REQ-037 Reset asserted mid-transfer abandons the transfer without a done pulse; after release the block accepts a new start.

Verification
REQ-038 start_addr=0x1000, xfer_words=40, MAX_BURST=16 -> three bursts: addr 0x1000/len 15, 0x1040/len 15, 0x1080/len 7; words_done=40; done=1 for exactly one cycle; error=0.
REQ-039 start_addr=0x1FF0, xfer_words=10 -> bursts 0x1FF0/len 3 and 0x2000/len 5; no 4 KB crossing.
REQ-040 Engine returns eng_error=1 on the second burst of a 3-burst transfer -> no third eng_valid; error=1; words_done=16; done pulses once.
REQ-041 start_addr=0x1002 -> error=1 and done one cycle later with zero eng_valid cycles; xfer_words=0 -> done with error=0.
REQ-042 eng_dma_ready held high for TIMEOUT cycles in ISSUE -> error=1, eng_valid drops, done pulses; a second start pulsed while busy has no effect.
REQ-043 rst_n pulsed low during WAIT_DONE -> all outputs are 0 immediately, with no done pulse; a following start runs to completion normally.
